// File: rtl/fft_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fft_pkg
// Purpose  : Shared constants and the round-robin pick helper used by
//            round_arbiter.
// Contents : IN_W_DEF  - default product width (32)
//            OUT_W_DEF - default result width (16)
//            rr_pick() - first valid index searching upward from ptr, mod n
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fft_pkg;

   localparam int IN_W_DEF  = 32;
   localparam int OUT_W_DEF = 16;

   // Returns the first index i with valid[i] set, scanning ptr, ptr+1, ...
   // modulo n. valid is zero-extended to 8 bits so one helper serves every
   // legal requester count (2..8). Returns 0 when nothing is valid; callers
   // qualify the result with |valid.
   function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input int         n);
      logic [2:0] pick;
      logic [2:0] idx3;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx  = (int'(ptr) + k) % n;
         idx3 = 3'(idx);
         if (!found && (k < n) && valid[idx3]) begin
            pick  = idx3;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : round_stage
// Purpose  : Combinational reduction of a two's-complement product from IN_W
//            to OUT_W bits.
// Config   : ROUND_ARBITER_ROUND_NEAREST_EN
//              undefined - truncation (arithmetic shift right, no adder)
//              defined   - round-half-up with one guard bit, saturating to
//                          the largest positive OUT_W value
// Ports    : in_data  [IN_W-1:0]  product in
//            out_data [OUT_W-1:0] reduced result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module round_stage
   import fft_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [IN_W-1:0]  in_data,
   output logic [OUT_W-1:0] out_data
);

   localparam int SHIFT = IN_W - OUT_W;

`ifdef ROUND_ARBITER_ROUND_NEAREST_EN
   localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);

   logic [IN_W:0]  sum_w;      // sign-extended by one guard bit
   logic [OUT_W:0] shifted_w;  // guard bit plus OUT_W result bits

   always_comb begin
      sum_w     = {in_data[IN_W-1], in_data} + HALF;
      shifted_w = sum_w[IN_W:SHIFT];
      // Adding a positive half-LSB can only overflow upward: guard bit clear
      // with the OUT_W sign bit set means the true result exceeds max positive.
      if (!shifted_w[OUT_W] && shifted_w[OUT_W-1]) begin
         out_data = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         out_data = shifted_w[OUT_W-1:0];
      end
   end

   logic unused_sum;
   assign unused_sum = ^sum_w[SHIFT-1:0];
`else
   assign out_data = in_data[IN_W-1:SHIFT];

   logic unused_low;
   assign unused_low = ^in_data[SHIFT-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/round_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : round_arbiter
// Purpose  : Round-robin arbiter over N_REQ product streams with a single
//            registered, rounded output stage (1-cycle latency, full
//            throughput, back-pressure aware).
// Config   : ROUND_ARBITER_ROUND_NEAREST_EN (see round_stage)
// Ports    : clk        clock, rising edge
//            rst_n      asynchronous active-low reset
//            req_valid  [N_REQ]        per-requester valid
//            req_data   [N_REQ][IN_W]  per-requester product
//            req_ready  [N_REQ]        per-requester accept (one-hot or zero)
//            out_valid / out_ready     output handshake
//            out_data   [OUT_W]        rounded result
//            out_id     [clog2(N_REQ)] source requester of out_data
//            busy                      output pending or any request valid
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module round_arbiter
   import fft_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0][IN_W-1:0]  req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_data,
   output logic [ID_W-1:0]             out_id,
   output logic                        busy
);

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic [ID_W-1:0]  out_id_q,    out_id_d;
   logic [ID_W-1:0]  ptr_q,       ptr_d;

   logic [7:0]       valid_ext;
   logic [2:0]       ptr_ext;
   logic [2:0]       grant;
   logic [ID_W-1:0]  grant_id;
   logic             grant_last;
   logic             grant_en;
   logic [IN_W-1:0]  sel_data;
   logic [OUT_W-1:0] rounded;

   // Widen to the fixed 8-bit helper interface.
   always_comb begin
      valid_ext = '0;
      for (int i = 0; i < N_REQ; i++) begin
         valid_ext[i] = req_valid[i];
      end
      ptr_ext             = '0;
      ptr_ext[ID_W-1:0]   = ptr_q;
   end

   always_comb begin
      grant      = rr_pick(valid_ext, ptr_ext, N_REQ);
      grant_id   = grant[ID_W-1:0];
      grant_last = (grant == 3'(N_REQ - 1));
      // Accept only when the output register is free or draining this cycle.
      grant_en   = (|req_valid) && (!out_valid_q || out_ready);
      sel_data   = req_data[grant_id];
   end

   round_stage #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_round_stage (
      .in_data  (sel_data),
      .out_data (rounded)
   );

   // rst_n gates the grant so req_ready is forced low asynchronously.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = rst_n && grant_en && (grant_id == ID_W'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
      if (grant_en) begin
         // Covers both an idle register and a same-cycle drain (no bubble).
         out_valid_d = 1'b1;
         out_data_d  = rounded;
         out_id_d    = grant_id;
         ptr_d       = grant_last ? '0 : grant_id + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign busy      = out_valid_q || (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_round_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_round_arbiter
// Purpose  : Directed self-checking bench for round_arbiter (N_REQ=4,
//            IN_W=32, OUT_W=16). Expected values are hand-computed.
// Config   : ROUND_ARBITER_ROUND_NEAREST_EN selects rounding expectations
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_round_arbiter;

   localparam int N_REQ = 4;
   localparam int IN_W  = 32;
   localparam int OUT_W = 16;

   logic                       clk;
   logic                       rst_n;
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0][IN_W-1:0] req_data;
   logic [N_REQ-1:0]           req_ready;
   logic                       out_valid;
   logic                       out_ready;
   logic [OUT_W-1:0]           out_data;
   logic [1:0]                 out_id;
   logic                       busy;

   int checks;
   int errors;

   round_arbiter #(
      .N_REQ (N_REQ),
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1 time unit later, well away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single request on requester idx, checks grant and registered result.
   task automatic single(input int idx, input logic [31:0] data,
                         input logic [15:0] exp, input string tag);
      req_valid       = '0;
      req_valid[idx]  = 1'b1;
      req_data[idx]   = data;
      out_ready       = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
      step();
      req_valid = '0;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(exp));
      chk({tag, "_id"},    32'(out_id),    32'(idx));
   endtask

   logic [15:0] exp_neg, exp_sat, exp_half, exp_8000;
   logic [1:0]  ptr_before_rst;

   initial begin
      checks    = 0;
      errors    = 0;
`ifdef ROUND_ARBITER_ROUND_NEAREST_EN
      exp_neg  = 16'h0000;
      exp_sat  = 16'h7FFF;
      exp_half = 16'h0002;
      exp_8000 = 16'hABCE;
`else
      exp_neg  = 16'hFFFF;
      exp_sat  = 16'h7FFF;
      exp_half = 16'h0001;
      exp_8000 = 16'hABCD;
`endif
      rst_n     = 1'b0;
      req_valid = 4'b1111;   // requests during reset must not be granted
      req_data  = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_id",    32'(out_id),    32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      #2 rst_n = 1'b1;
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      // Reset then single request on requester 0
      single(0, 32'h12345678, 16'h1234, "first");
      chk("first_busy", 32'(busy), 32'd1);
      step();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Requester 3 alone moves ptr 1 -> wraps to 0
      single(3, 32'h0003_FFFF, 16'h0003, "wrap");

      // All four valid for 8 cycles: order 0,1,2,3,0,1,2,3
      for (int i = 0; i < N_REQ; i++) req_data[i] = ((i + 1) << 16) | 32'h0000_7FFF;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         step();
         chk($sformatf("rr_id%0d", k),    32'(out_id),    32'(k % 4));
         chk($sformatf("rr_valid%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("rr_data%0d", k),  32'(out_data),  32'((k % 4) + 1));
      end

      // Back-pressure with pending result from 0xABCD8000 (ptr is 0)
      req_valid   = 4'b0001;
      req_data[0] = 32'hABCD_8000;
      step();
      chk("bp_load", 32'(out_data), 32'(exp_8000));
      out_ready = 1'b0;
      req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
         step();
         chk($sformatf("bp_data%0d", k),  32'(out_data),  32'(exp_8000));
         chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp_id%0d", k),    32'(out_id),    32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 32'(req_ready), 32'b0010);
      step();
      chk("bp_resume_id", 32'(out_id), 32'd1);
      req_valid = '0;

      // Rounding boundaries (ptr is 2)
      single(2, 32'hFFFF_8000, exp_neg,  "neg");
      single(3, 32'h7FFF_8000, exp_sat,  "sat");
      single(0, 32'h0001_8000, exp_half, "half");

      // Reset mid-stream with out_valid high, ptr non-zero
      req_valid = 4'b0010;
      step();
      ptr_before_rst = 2'd2;
      chk("mid_valid", 32'(out_valid), 32'd1);
      chk("mid_id",    32'(out_id),    32'(ptr_before_rst - 2'd1));
      req_valid = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_data",  32'(out_data),  32'd0);
      chk("async_ready", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'b0001);
      step();
      chk("post_rst_id",    32'(out_id),    32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      req_valid = '0;
      step();
      chk("final_idle", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
